// File: rtl/mul_sched_if.sv
// Requester and multiplier-side signal bundle for mul_sched.
// The slave modport is the scheduler; the master modport is whatever drives it.
interface mul_sched_if #(
    parameter int N    = 256,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_err;
    logic              mul_start;
    logic [N-1:0]      mul_a;
    logic [N-1:0]      mul_b;
    logic              mul_done;
    logic [N-1:0]      mul_prod;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_done, mul_prod,
        output req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_done, mul_prod,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one multi-cycle multiplier among NREQ requesters.
// Define MUL_SCHED_TIMEOUT_EN to build the WAIT watchdog (limit TMO cycles, flagged via rsp_err).
module mul_sched #(
    parameter int N    = 256,
    parameter int NREQ = 4,
    parameter int TMO  = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_sched_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [PW-1:0]   rr_ptr_r, owner_r, grant_idx_s, ptr_next_s;
    logic [PW:0]     scan_s;
    logic            grant_any_s, accept_s, done_s, expire_s;
    logic [NREQ-1:0] grant_oh_s, owner_oh_s, rsp_valid_r;
    logic [N-1:0]    mul_a_r, mul_b_r, rsp_data_r;
    logic            mul_start_r, busy_r;

    if ((NREQ < 2) || (NREQ > 8) || (TMO < 1)) begin : g_param_check
        $error("mul_sched: NREQ must be 2..8 and TMO at least 1");
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {PW{1'b0}};
        grant_oh_s  = {NREQ{1'b0}};
        scan_s      = {(PW+1){1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            scan_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
            if (scan_s >= (PW+1)'(NREQ)) begin
                scan_s = scan_s - (PW+1)'(NREQ);
            end else begin
                scan_s = scan_s;
            end
            if (!grant_any_s && bus.req_valid[scan_s[PW-1:0]]) begin
                grant_any_s = 1'b1;
                grant_idx_s = scan_s[PW-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
        if (grant_any_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = {NREQ{1'b0}};
        end
    end

    // Owner decode and pointer advance past the granted requester.
    always_comb begin
        owner_oh_s          = {NREQ{1'b0}};
        owner_oh_s[owner_r] = 1'b1;
        if (grant_idx_s == PW'(NREQ - 1)) begin
            ptr_next_s = {PW{1'b0}};
        end else begin
            ptr_next_s = grant_idx_s + PW'(1);
        end
    end

    assign accept_s      = (state_r == IDLE) && grant_any_s;
    assign done_s        = (state_r == WAIT) && bus.mul_done;
    assign bus.req_ready = ((state_r == IDLE) && rst_n) ? grant_oh_s : {NREQ{1'b0}};

`ifdef MUL_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] wait_cnt_r;
    logic          rsp_err_r;

    // Watchdog counts WAIT cycles; a done in the final cycle takes priority over expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= {CW{1'b0}};
        end
    end

    assign expire_s = (state_r == WAIT) && (wait_cnt_r == CW'(TMO - 1)) && !bus.mul_done;

    // Error flag travels with the result and is held alongside rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else if (done_s) begin
            rsp_err_r <= 1'b0;
        end else if (expire_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign bus.rsp_err = rsp_err_r;
`else
    assign expire_s    = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = accept_s ? ISSUE : IDLE;
            ISSUE:   state_s = WAIT;
            WAIT:    state_s = (done_s || expire_s) ? RESP : WAIT;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, operand/result registers and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {PW{1'b0}};
            owner_r     <= {PW{1'b0}};
            mul_a_r     <= {N{1'b0}};
            mul_b_r     <= {N{1'b0}};
            rsp_data_r  <= {N{1'b0}};
            mul_start_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= {NREQ{1'b0}};
        end else begin
            state_r     <= state_s;
            mul_start_r <= (state_s == ISSUE);
            busy_r      <= (state_s != IDLE);
            rsp_valid_r <= (state_s == RESP) ? owner_oh_s : {NREQ{1'b0}};
            if (accept_s) begin
                mul_a_r  <= bus.req_a[int'(grant_idx_s)*N +: N];
                mul_b_r  <= bus.req_b[int'(grant_idx_s)*N +: N];
                owner_r  <= grant_idx_s;
                rr_ptr_r <= ptr_next_s;
            end else begin
                mul_a_r  <= mul_a_r;
                mul_b_r  <= mul_b_r;
                owner_r  <= owner_r;
                rr_ptr_r <= rr_ptr_r;
            end
            if (done_s) begin
                rsp_data_r <= bus.mul_prod;
            end else if (expire_s) begin
                rsp_data_r <= {N{1'b0}};
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign bus.mul_start = mul_start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural multiplier of programmable latency.
module tb_mul_sched;
    localparam int N = 256;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*N-1:0] req_b = '0;
    logic spur_done = 1'b0;
    logic model_done;
    logic [N-1:0] model_prod, prod_m;
    logic model_en = 1'b1;
    logic model_busy;
    int   model_lat = 10;
    int   rem_m;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    mul_sched_if #(.N(N), .NREQ(NREQ)) bus ();

    assign bus.req_valid = req_valid;
    assign bus.req_a     = req_a;
    assign bus.req_b     = req_b;
    assign bus.mul_done  = model_done | spur_done;
    assign bus.mul_prod  = model_prod;

    mul_sched #(.N(N), .NREQ(NREQ), .TMO(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Multiplier model: done pulses model_lat cycles after the start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done <= 1'b0; model_busy <= 1'b0; model_prod <= '0; rem_m <= 0; prod_m <= '0;
        end else begin
            model_done <= 1'b0;
            if (bus.mul_start && model_en) begin
                if (model_lat == 1) begin
                    model_done <= 1'b1; model_prod <= bus.mul_a * bus.mul_b;
                end else begin
                    model_busy <= 1'b1; rem_m <= model_lat - 1; prod_m <= bus.mul_a * bus.mul_b;
                end
            end else if (model_busy) begin
                if (rem_m == 1) begin
                    model_done <= 1'b1; model_prod <= prod_m; model_busy <= 1'b0;
                end else begin
                    rem_m <= rem_m - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    // Advance until any rsp_valid; an expired bound counts as a failure.
    task automatic wait_rsp(input string name, output int at);
        int n = 0;
        while (bus.rsp_valid === '0 && n < 100) begin tick(); n++; end
        at = cyc;
        if (bus.rsp_valid === '0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: no rsp_valid within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0000", bus.rsp_valid); end
        checks++; if (bus.mul_start !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_start_ready: got %b/%b want 0/0000", bus.mul_start, bus.req_ready); end
        checks++; if (bus.mul_a !== '0 || bus.rsp_data !== '0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_data: got a=%0h d=%0h e=%0b want 0", bus.mul_a, bus.rsp_data, bus.rsp_err); end
        rst_n = 1'b1; tick();
    endtask

    task automatic test_single();
        int t0, tr;
        model_lat = 10;
        set_req(2, 256'd3, 256'd5); req_valid = 4'b0100; #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        t0 = cyc; tick(); req_valid = 4'b0000; #1;
        checks++; if (bus.mul_start !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_start: got start=%0b busy=%0b want 1/1", bus.mul_start, bus.busy); end
        checks++; if (bus.mul_a !== 256'd3 || bus.mul_b !== 256'd5) begin errors++; $display("FAIL single_ops: got %0h,%0h want 3,5", bus.mul_a, bus.mul_b); end
        tick();
        checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %0b want 0", bus.mul_start); end
        wait_rsp("single", tr);
        checks++; if (tr - t0 !== 12) begin errors++; $display("FAIL single_latency: got %0d want 12", tr - t0); end
        checks++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 256'd15 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got v=%b d=%0h e=%0b want 0100/f/0", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        tick();
        checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_after: got busy=%0b v=%b want 0/0000", bus.busy, bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 256'd15) begin errors++; $display("FAIL single_hold: got %0h want f", bus.rsp_data); end
    endtask

    // Continuous requests from all four, starting from a fresh reset; accepts every lat+3 cycles.
    task automatic test_round_robin();
        int last, n;
        model_lat = 3;
        rst_n = 1'b0; tick();
        for (int i = 0; i < NREQ; i++) set_req(i, N'(i + 1), 256'd10);
        req_valid = 4'b1111; rst_n = 1'b1; #1;
        last = cyc;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (bus.req_ready === 4'b0000 && n < 30) begin tick(); n++; end
            checks++; if (bus.req_ready !== 4'(1 << (g % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, bus.req_ready, 4'(1 << (g % 4))); end
            if (g > 0) begin
                checks++; if (cyc - last !== 6) begin errors++; $display("FAIL rr_gap%0d: got %0d want 6", g, cyc - last); end
            end
            last = cyc;
            tick();
        end
    endtask

    // Requester 1 was just served (pointer now 2): alone, it must win by wrapping.
    task automatic test_wrap();
        int t0, tr, n;
        t0 = cyc - 1;
        set_req(1, 256'd7, 256'd6); req_valid = 4'b0010; #1;
        n = 0;
        while (bus.req_ready === 4'b0000 && n < 30) begin tick(); n++; end
        checks++; if (bus.req_ready !== 4'b0010 || cyc - t0 !== 6) begin errors++; $display("FAIL wrap_grant: got %b at +%0d want 0010 at +6", bus.req_ready, cyc - t0); end
        t0 = cyc; tick(); req_valid = 4'b0000;
        wait_rsp("wrap", tr);
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 256'd42 || tr - t0 !== 5) begin errors++; $display("FAIL wrap_rsp: got v=%b d=%0h at +%0d want 0010/2a at +5", bus.rsp_valid, bus.rsp_data, tr - t0); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0, tr;
        logic [N-1:0] big;
        big = {1'b1, 255'd0};
        model_lat = 10;
        set_req(3, 256'd9, 256'd9); req_valid = 4'b1000; tick(); req_valid = 4'b0000;
        repeat (4) tick();
        rst_n = 1'b0; #1;
        checks++; if (bus.busy !== 1'b0 || bus.mul_a !== '0 || bus.rsp_data !== '0) begin errors++; $display("FAIL midrst_clear: got busy=%0b a=%0h d=%0h want 0", bus.busy, bus.mul_a, bus.rsp_data); end
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin tick(); if (bus.rsp_valid !== 4'b0000) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_stale: got %0d pulses want 0", seen); end
        model_lat = 2;
        set_req(0, big, 256'd2); req_valid = 4'b0001; tick(); req_valid = 4'b0000; #1;
        checks++; if (bus.mul_a !== big || bus.mul_b !== 256'd2) begin errors++; $display("FAIL midrst_ops: got %0h,%0h want 2^255,2", bus.mul_a, bus.mul_b); end
        wait_rsp("midrst", tr);
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 256'd0) begin errors++; $display("FAIL midrst_rsp: got v=%b d=%0h want 0001/0", bus.rsp_valid, bus.rsp_data); end
        tick();
    endtask

    // Spurious done in IDLE is ignored; then a 1-cycle multiplier (done in first WAIT cycle).
    task automatic test_spurious();
        int seen = 0, t0, tr;
        tick(); spur_done = 1'b1; tick(); spur_done = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(); if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL spur_ignored: got %0d bad cycles want 0", seen); end
        model_lat = 1;
        set_req(3, 256'd11, 256'd13); req_valid = 4'b1000; #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL spur_idle_ready: got %b want 1000", bus.req_ready); end
        t0 = cyc; tick(); req_valid = 4'b0000;
        wait_rsp("fast", tr);
        checks++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 256'd143 || tr - t0 !== 3) begin errors++; $display("FAIL fast_rsp: got v=%b d=%0h at +%0d want 1000/8f at +3", bus.rsp_valid, bus.rsp_data, tr - t0); end
        tick();
    endtask

`ifdef MUL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int t0, tr;
        model_en = 1'b0;
        set_req(2, 256'd4, 256'd4); req_valid = 4'b0100; t0 = cyc; tick(); req_valid = 4'b0000;
        wait_rsp("tmo", tr);
        checks++; if (bus.rsp_valid !== 4'b0100 || tr - t0 !== 22) begin errors++; $display("FAIL tmo_when: got v=%b at +%0d want 0100 at +22", bus.rsp_valid, tr - t0); end
        checks++; if (bus.rsp_data !== 256'd0 || bus.rsp_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got d=%0h e=%0b want 0/1", bus.rsp_data, bus.rsp_err); end
        tick();
        model_en = 1'b1; model_lat = 20;
        req_valid = 4'b0100; t0 = cyc; tick(); req_valid = 4'b0000;
        wait_rsp("tmo_race", tr);
        checks++; if (tr - t0 !== 22 || bus.rsp_data !== 256'd16 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_race: got +%0d d=%0h e=%0b want +22/10/0", tr - t0, bus.rsp_data, bus.rsp_err); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_spurious();
`ifdef MUL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
